float_add_sequencer: RTL
========================

// Module: float_add_sequencer
// PURPOSE
//  Upstream issue/capture controller for the single-precision float adder (start_i/busy_o handshake).
//  Buffers operand pairs from a valid/ready stream in a small FIFO and issues them one at a time.
//  Drives start and holds the operands stable, then waits for busy to rise and fall.
//  Captures the sum into a valid/ready output register. A watchdog flags a hung adder.
// PARAMETERS
//  DEPTH        4    operand FIFO entries; power of 2, >=2
//  TIMEOUT      64   max cycles spent in WAIT_BUSY+WAIT_DONE for one op before abort; >=2
// PORTS
//  clk_i         in   1   clock, all logic on posedge
//  rst_i         in   1   reset; synchronous, active-high
//  s_valid_i     in   1   operand pair valid
//  s_ready_o     out  1   FIFO not full
//  s_a_i         in   32  operand A, IEEE-754 single
//  s_b_i         in   32  operand B, IEEE-754 single
//  m_valid_o     out  1   sum valid
//  m_ready_i     in   1   consumer accepts sum
//  m_sum_o       out  32  captured sum
//  m_timeout_o   out  1   sticky: at least one op aborted by watchdog
//  add_start_o   out  1   to adder start_i
//  add_busy_i    in   1   from adder busy_o
//  add_a_o       out  32  to adder in_a
//  add_b_o       out  32  to adder in_b
//  add_sum_i     in   32  from adder out_sum
// BEHAVIOUR
//  Reset (rst_i=1 at a posedge): state=IDLE; FIFO emptied (count=0, pointers=0); watchdog=0.
//   Outputs after reset: s_ready_o=1, m_valid_o=0, m_sum_o=0, m_timeout_o=0, add_start_o=0.
//   Also add_a_o=0, add_b_o=0. Reset mid-op abandons it; no result is emitted.
//  FIFO: push when s_valid_i&&s_ready_o. s_ready_o = (count!=DEPTH), from registered count.
//   Data is poppable the cycle after the push. Pointers wrap modulo DEPTH.
//   Simultaneous push+pop leaves count unchanged. When full, s_ready_o=0 and no push occurs.
//  Output register: load sets m_valid_o=1. Transfer when m_valid_o&&m_ready_i clears m_valid_o.
//   m_sum_o holds while m_valid_o=1 && m_ready_i=0.
//  FSM:
//   IDLE:      if FIFO non-empty && m_valid_o==0: pop head into add_a_o/add_b_o, go ISSUE; else stay.
//   ISSUE:     add_start_o=1 for exactly this one cycle; watchdog cleared; go WAIT_BUSY.
//   WAIT_BUSY: if add_busy_i -> WAIT_DONE.
//   WAIT_DONE: if !add_busy_i: m_sum_o<=add_sum_i, m_valid_o<=1, go IDLE.
//  Watchdog: increments every cycle in WAIT_BUSY/WAIT_DONE.
//   When it reaches TIMEOUT-1 without completion: go IDLE, set m_timeout_o, discard the result.
//   Completion and timeout in the same cycle: completion wins.
//  add_a_o/add_b_o change only on a pop; stable from ISSUE through WAIT_DONE exit.
//  add_start_o is never high outside ISSUE; never two start pulses without busy fall/abort between.
//  At most one op is in flight; results leave in FIFO order.
//  Min latency, pop to m_valid_o: 4 cycles plus adder busy duration.
//  The m_valid_o==0 gate on IDLE prevents overwriting an unread sum.
//  m_ready_i is observed only through m_valid_o; it can stall issue, never corrupt data.
// TESTING
//  Bench uses a behavioural adder model: busy rises 1 cycle after start, held N cycles.
//  1) Single op: a=0x3F800000, b=0x40000000, m_ready_i=1.
//     -> one add_start_o pulse; m_sum_o=0x40400000, m_valid_o=1 for 1 cycle.
//  2) Burst of 6 pairs, DEPTH=4, m_ready_i=1.
//     -> s_ready_o drops while count=4; all 6 sums return in order, none lost.
//  3) Backpressure: m_ready_i=0 for 20 cycles with 2 ops queued.
//     -> first sum held stable, no second add_start_o until it is accepted.
//  4) Hung adder: busy never rises.
//     -> abort after TIMEOUT cycles, m_timeout_o=1 sticky, m_valid_o stays 0, next op proceeds.
//  5) rst_i asserted in WAIT_DONE with 3 entries queued.
//     -> next cycle: s_ready_o=1, m_valid_o=0, add_start_o=0, m_timeout_o=0; the queue is empty.
//  6) Push and pop in the same cycle at count=2.
//     -> count stays 2; pointer wrap past DEPTH-1 verified with 10 sequential ops.

Source files
------------

// File: rtl/float_add_sequencer.sv
// Buffers operand pairs, issues them one at a time to a start/busy float adder, captures sums in order.
// Pop to m_valid_o >= 4 cycles + adder busy; s_ready_o drops when FIFO full; unread sum stalls issue.
module float_add_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [31:0] s_a_i,
    input  logic [31:0] s_b_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [31:0] m_sum_o,
    output logic        m_timeout_o,
    output logic        add_start_o,
    input  logic        add_busy_i,
    output logic [31:0] add_a_o,
    output logic [31:0] add_b_o,
    input  logic [31:0] add_sum_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } operand_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    operand_t      fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    state_t        next_state;
    logic [WW-1:0] wdog;
    logic          push;
    logic          pop;
    logic          complete;
    logic          abort;

    assign s_ready_o = (count != FULL_CNT);
    assign push      = s_valid_i && s_ready_o;
    // An unread sum blocks the next pop so it can never be overwritten.
    assign pop       = (state == IDLE) && (count != '0) && !m_valid_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s_a_i, s_b_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        add_start_o = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (pop) next_state = ISSUE;
            end
            ISSUE: begin
                add_start_o = 1'b1;
                next_state  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wdog == WD_LAST) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (add_busy_i) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (!add_busy_i) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end else if (wdog == WD_LAST) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog        <= '0;
            add_a_o     <= '0;
            add_b_o     <= '0;
            m_valid_o   <= 1'b0;
            m_sum_o     <= '0;
            m_timeout_o <= 1'b0;
        end else begin
            if (pop) begin
                add_a_o <= fifo_mem[rd_ptr].a;
                add_b_o <= fifo_mem[rd_ptr].b;
            end
            if (state == ISSUE) begin
                wdog <= '0;
            end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
                wdog <= wdog + WW'(1);
            end
            if (abort) m_timeout_o <= 1'b1;
            if (complete) begin
                m_sum_o   <= add_sum_i;
                m_valid_o <= 1'b1;
            end else if (m_valid_o && m_ready_i) begin
                m_valid_o <= 1'b0;
            end
        end
    end
endmodule
